// File: rtl/lcd_msg_arbiter.sv
// lcd_msg_arbiter: shares one LCD controller among three requesters.
//
// A requester raises its req bit and holds it until it sees done or err.
// The arbiter grants the LCD in round-robin order, latches the winner's two
// text lines, raises lcd_sendText, and then waits for lcd_sendingDone or a
// timeout. Afterwards it holds the grant until lcd_sendingDone is low again,
// so that a level-style completion flag is never mistaken for the next
// transfer's completion.
//
// Ports:
//   CLK              clock, rising edge
//   RESET            asynchronous active-high reset
//   req[2:0]         per-requester display request
//   line1_0..2       line-1 text of requester 0/1/2 (8*LINE_LENGTH bits)
//   line2_0..2       line-2 text of requester 0/1/2 (8*LINE_LENGTH bits)
//   grant[2:0]       one-hot owner of the LCD, zero when idle
//   done[2:0]        one-cycle pulse to the owner on successful transfer
//   err[2:0]         one-cycle pulse to the owner on timeout
//   lcd_sendText     send request to the LCD controller
//   lcd_line1/2      latched text presented to the LCD controller
//   lcd_sendingDone  completion flag from the LCD controller (pulse or level)

module lcd_msg_arbiter #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd5000000,
    parameter int unsigned LINE_LENGTH    = 16
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [2:0]                 req,
    input  logic [8*LINE_LENGTH-1:0]   line1_0,
    input  logic [8*LINE_LENGTH-1:0]   line1_1,
    input  logic [8*LINE_LENGTH-1:0]   line1_2,
    input  logic [8*LINE_LENGTH-1:0]   line2_0,
    input  logic [8*LINE_LENGTH-1:0]   line2_1,
    input  logic [8*LINE_LENGTH-1:0]   line2_2,
    output logic [2:0]                 grant,
    output logic [2:0]                 done,
    output logic [2:0]                 err,
    output logic                       lcd_sendText,
    output logic [8*LINE_LENGTH-1:0]   lcd_line1,
    output logic [8*LINE_LENGTH-1:0]   lcd_line2,
    input  logic                       lcd_sendingDone
);

    localparam int unsigned LineW = 8 * LINE_LENGTH;

    // Last counter value before a timeout fires; the counter saturates here.
    localparam logic [23:0] TimeoutLast = TIMEOUT_CYCLES - 24'd1;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StRelease
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         grant_q, grant_d;
    logic [2:0]         done_q, done_d;
    logic [2:0]         err_q, err_d;
    logic               send_q, send_d;
    logic [LineW-1:0]   line1_q, line1_d;
    logic [LineW-1:0]   line2_q, line2_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [23:0]        cnt_q, cnt_d;

    logic               pick_valid;
    logic [1:0]         pick_idx;
    logic [1:0]         owner_idx;
    logic [LineW-1:0]   pick_line1;
    logic [LineW-1:0]   pick_line2;

    // (base + off) mod 3 for base, off in 0..2.
    function automatic logic [1:0] rr_idx(input logic [1:0] base, input logic [1:0] off);
        logic [2:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= 3'd3) begin
            sum = sum - 3'd3;
        end
        return sum[1:0];
    endfunction

    // Round-robin pick: scan offsets from farthest to nearest so the
    // requester closest to ptr_q is the one left standing.
    always_comb begin
        logic [1:0] idx;
        pick_valid = 1'b0;
        pick_idx   = 2'd0;
        for (int off = 2; off >= 0; off--) begin
            idx = rr_idx(ptr_q, 2'(off));
            if (req[idx]) begin
                pick_valid = 1'b1;
                pick_idx   = idx;
            end
        end
    end

    always_comb begin
        pick_line1 = line1_0;
        pick_line2 = line2_0;
        unique case (pick_idx)
            2'd1: begin
                pick_line1 = line1_1;
                pick_line2 = line2_1;
            end
            2'd2: begin
                pick_line1 = line1_2;
                pick_line2 = line2_2;
            end
            default: begin
                pick_line1 = line1_0;
                pick_line2 = line2_0;
            end
        endcase
    end

    always_comb begin
        owner_idx = 2'd0;
        if (grant_q[1]) begin
            owner_idx = 2'd1;
        end
        if (grant_q[2]) begin
            owner_idx = 2'd2;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        done_d  = 3'b000;
        err_d   = 3'b000;
        send_d  = send_q;
        line1_d = line1_q;
        line2_d = line2_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    grant_d           = 3'b000;
                    grant_d[pick_idx] = 1'b1;
                    line1_d           = pick_line1;
                    line2_d           = pick_line2;
                    send_d            = 1'b1;
                    cnt_d             = 24'd0;
                    state_d           = StSend;
                end
            end

            StSend: begin
                // Completion takes priority over a coincident timeout.
                if (lcd_sendingDone) begin
                    done_d  = grant_q;
                    send_d  = 1'b0;
                    ptr_d   = rr_idx(owner_idx, 2'd1);
                    state_d = StRelease;
                end else if (cnt_q == TimeoutLast) begin
                    err_d   = grant_q;
                    send_d  = 1'b0;
                    ptr_d   = rr_idx(owner_idx, 2'd1);
                    state_d = StRelease;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end

            StRelease: begin
                if (!lcd_sendingDone) begin
                    grant_d = 3'b000;
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
                grant_d = 3'b000;
                send_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= StIdle;
            grant_q <= 3'b000;
            done_q  <= 3'b000;
            err_q   <= 3'b000;
            send_q  <= 1'b0;
            line1_q <= '0;
            line2_q <= '0;
            ptr_q   <= 2'd0;
            cnt_q   <= 24'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            err_q   <= err_d;
            send_q  <= send_d;
            line1_q <= line1_d;
            line2_q <= line2_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant        = grant_q;
    assign done         = done_q;
    assign err          = err_q;
    assign lcd_sendText = send_q;
    assign lcd_line1    = line1_q;
    assign lcd_line2    = line2_q;

endmodule

// File: tb/tb_lcd_msg_arbiter.sv
// Testbench for lcd_msg_arbiter: cycle-by-cycle vector table for normal
// transfers, round-robin order and a long-held lcd_sendingDone, followed by
// hand-written sequences for timeout, reset mid-transfer, line stability and
// done/timeout coincidence.

module tb_lcd_msg_arbiter;

    localparam int unsigned LL = 16;
    localparam int unsigned W  = 8 * LL;

    logic         CLK;
    logic         RESET;
    logic [2:0]   req;
    logic [W-1:0] l1 [3];
    logic [W-1:0] l2 [3];
    logic [2:0]   grant;
    logic [2:0]   done;
    logic [2:0]   err;
    logic         lcd_sendText;
    logic [W-1:0] lcd_line1;
    logic [W-1:0] lcd_line2;
    logic         sd;

    int n_cmp;
    int n_fail;

    lcd_msg_arbiter #(
        .TIMEOUT_CYCLES (24'd8),
        .LINE_LENGTH    (LL)
    ) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .req             (req),
        .line1_0         (l1[0]),
        .line1_1         (l1[1]),
        .line1_2         (l1[2]),
        .line2_0         (l2[0]),
        .line2_1         (l2[1]),
        .line2_2         (l2[2]),
        .grant           (grant),
        .done            (done),
        .err             (err),
        .lcd_sendText    (lcd_sendText),
        .lcd_line1       (lcd_line1),
        .lcd_line2       (lcd_line2),
        .lcd_sendingDone (sd)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic [2:0] req;
        logic       sd;
        logic [2:0] grant;
        logic [2:0] done;
        logic [2:0] err;
        logic       send;
    } vec_t;

    vec_t tbl [24];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic int onehot_idx(input logic [2:0] g);
        if (g[1]) return 1;
        if (g[2]) return 2;
        return 0;
    endfunction

    initial begin
        logic [W-1:0] old_l1;
        int sends, errs, dones, idx;

        n_cmp  = 0;
        n_fail = 0;
        l1[0] = 128'h3031_3233_3435_3637_3839_4142_4344_4546;
        l1[1] = 128'h4748_494A_4B4C_4D4E_4F50_5152_5354_5556;
        l1[2] = 128'h5758_595A_6162_6364_6566_6768_696A_6B6C;
        l2[0] = 128'hA0A1_A2A3_A4A5_A6A7_A8A9_AAAB_ACAD_AEAF;
        l2[1] = 128'hB0B1_B2B3_B4B5_B6B7_B8B9_BABB_BCBD_BEBF;
        l2[2] = 128'hC0C1_C2C3_C4C5_C6C7_C8C9_CACB_CCCD_CECF;

        //              req     sd    grant   done    err     send
        // single transfer from requester 0, done 5 cycles after send rises
        tbl[0]  = '{3'b001, 1'b0, 3'b001, 3'b000, 3'b000, 1'b1};
        tbl[1]  = '{3'b001, 1'b0, 3'b001, 3'b000, 3'b000, 1'b1};
        tbl[2]  = '{3'b001, 1'b0, 3'b001, 3'b000, 3'b000, 1'b1};
        tbl[3]  = '{3'b001, 1'b0, 3'b001, 3'b000, 3'b000, 1'b1};
        tbl[4]  = '{3'b001, 1'b0, 3'b001, 3'b000, 3'b000, 1'b1};
        tbl[5]  = '{3'b001, 1'b1, 3'b001, 3'b001, 3'b000, 1'b0};
        tbl[6]  = '{3'b000, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0};
        tbl[7]  = '{3'b000, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0};
        // all three requesting: 010, 100, 001 (ptr is 1 after requester 0)
        tbl[8]  = '{3'b111, 1'b0, 3'b010, 3'b000, 3'b000, 1'b1};
        tbl[9]  = '{3'b111, 1'b1, 3'b010, 3'b010, 3'b000, 1'b0};
        tbl[10] = '{3'b111, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0};
        tbl[11] = '{3'b111, 1'b0, 3'b100, 3'b000, 3'b000, 1'b1};
        tbl[12] = '{3'b111, 1'b1, 3'b100, 3'b100, 3'b000, 1'b0};
        tbl[13] = '{3'b111, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0};
        tbl[14] = '{3'b111, 1'b0, 3'b001, 3'b000, 3'b000, 1'b1};
        tbl[15] = '{3'b111, 1'b1, 3'b001, 3'b001, 3'b000, 1'b0};
        // sendingDone held high: grant held in release until it falls
        tbl[16] = '{3'b111, 1'b1, 3'b001, 3'b000, 3'b000, 1'b0};
        tbl[17] = '{3'b111, 1'b1, 3'b001, 3'b000, 3'b000, 1'b0};
        tbl[18] = '{3'b111, 1'b1, 3'b001, 3'b000, 3'b000, 1'b0};
        tbl[19] = '{3'b111, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0};
        tbl[20] = '{3'b111, 1'b0, 3'b010, 3'b000, 3'b000, 1'b1};
        tbl[21] = '{3'b111, 1'b1, 3'b010, 3'b010, 3'b000, 1'b0};
        tbl[22] = '{3'b000, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0};
        tbl[23] = '{3'b000, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0};

        // Reset: outputs clear before any clock edge
        RESET = 1'b1;
        req   = 3'b000;
        sd    = 1'b0;
        #2;
        check("rst grant", grant, 0);
        check("rst done", done, 0);
        check("rst err", err, 0);
        check("rst send", lcd_sendText, 0);
        check("rst line1", lcd_line1, 0);
        check("rst line2", lcd_line2, 0);
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;

        for (int i = 0; i < 24; i++) begin
            req = tbl[i].req;
            sd  = tbl[i].sd;
            step();
            check($sformatf("v%0d grant", i), grant, tbl[i].grant);
            check($sformatf("v%0d done", i), done, tbl[i].done);
            check($sformatf("v%0d err", i), err, tbl[i].err);
            check($sformatf("v%0d send", i), lcd_sendText, tbl[i].send);
            if (tbl[i].grant != 3'b000) begin
                idx = onehot_idx(tbl[i].grant);
                check($sformatf("v%0d line1", i), lcd_line1, l1[idx]);
                check($sformatf("v%0d line2", i), lcd_line2, l2[idx]);
            end
        end

        // Timeout: ptr is 2, req=001 still wins; send high exactly 8 cycles
        req   = 3'b001;
        sd    = 1'b0;
        sends = 0;
        errs  = 0;
        dones = 0;
        step();
        check("to grant", grant, 3'b001);
        if (lcd_sendText) sends++;
        for (int i = 0; i < 15; i++) begin
            step();
            if (lcd_sendText) sends++;
            if (done != 3'b000) dones++;
            if (err != 3'b000) begin
                errs++;
                check("to err owner", err, 3'b001);
                check("to send low at err", lcd_sendText, 0);
                req = 3'b000;
            end
        end
        check("to send cycles", sends, 8);
        check("to err pulses", errs, 1);
        check("to done pulses", dones, 0);
        check("to grant idle", grant, 0);

        // ptr advanced to 1 after the timeout
        req = 3'b011;
        step();
        check("to next grant", grant, 3'b010);
        sd = 1'b1;
        step();
        check("to next done", done, 3'b010);
        sd  = 1'b0;
        req = 3'b000;
        step();
        check("to next release", grant, 0);

        // Reset mid-SEND: ptr is 2, requester 1 granted
        req = 3'b010;
        step();
        check("rs grant", grant, 3'b010);
        step();
        #2;
        RESET = 1'b1;
        #1;
        check("rs async grant", grant, 0);
        check("rs async send", lcd_sendText, 0);
        check("rs async line1", lcd_line1, 0);
        check("rs async done", done, 0);
        check("rs async err", err, 0);
        @(posedge CLK);
        #1;
        check("rs held done", done, 0);
        check("rs held err", err, 0);
        @(negedge CLK);
        RESET = 1'b0;
        req   = 3'b011;
        step();
        check("rs prio grant", grant, 3'b001);
        check("rs prio line1", lcd_line1, l1[0]);

        // Line change during SEND, then done coinciding with timeout
        old_l1 = l1[0];
        repeat (3) step();
        l1[0] = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
        repeat (4) step();
        check("ln stable line1", lcd_line1, old_l1);
        check("ln still sending", lcd_sendText, 1);
        sd = 1'b1;
        step();
        check("co done wins", done, 3'b001);
        check("co no err", err, 0);
        sd  = 1'b0;
        req = 3'b000;
        step();
        check("co release", grant, 0);
        step();
        check("ln idle line1", lcd_line1, old_l1);
        check("ln idle line2", lcd_line2, l2[0]);
        check("co done once", done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_msg_arbiter.md
LCD_MSG_ARBITER -- requirements
Module: lcd_msg_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 24'd5000000; max CLK cycles SEND may wait for lcd_sendingDone.
REQ-002 Parameter LINE_LENGTH, default 16; characters per LCD line (8 bits each).
REQ-003 CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 req  input  3  per-requester display request; held high by requester until its done or err pulse.
REQ-006 line1_0, line1_1, line1_2  input  8*LINE_LENGTH  line-1 text of requester 0/1/2.
REQ-007 line2_0, line2_1, line2_2  input  8*LINE_LENGTH  line-2 text of requester 0/1/2.
REQ-008 grant  output  3  one-hot owner of the LCD; zero when idle.
REQ-009 done  output  3  one-cycle pulse to the owner on successful transfer.
REQ-010 err  output  3  one-cycle pulse to the owner on timeout.
REQ-011 lcd_sendText  output  1  send request to the LCD controller.
REQ-012 lcd_line1, lcd_line2  output  8*LINE_LENGTH  latched text presented to the LCD controller.
REQ-013 lcd_sendingDone  input  1  completion flag from the LCD controller (pulse or level).

Function
REQ-014 FSM states IDLE, SEND, RELEASE; exactly one active at any time.
REQ-015 IDLE: if req != 0 at a rising edge, register a one-hot grant chosen round-robin, latch that requester's line1_x/line2_x into lcd_line1/lcd_line2, and go to SEND.
REQ-016 Round-robin: search starts at pointer ptr (0..2) and wraps 2->0; ptr becomes (granted index + 1) mod 3 when the transfer ends (done or err).
REQ-017 SEND: lcd_sendText = 1 (registered), first high in the cycle after the grant edge, and held high until exit from SEND.
REQ-018 SEND: lcd_sendingDone sampled high -> done[owner] pulses 1 cycle, lcd_sendText drops, and the FSM goes to RELEASE.
REQ-019 SEND: a timeout counter starts at 0 on entry and increments each cycle; at count == TIMEOUT_CYCLES-1 without done -> err[owner] pulses 1 cycle, lcd_sendText drops, and the FSM goes to RELEASE.
REQ-020 Done and timeout in the same cycle: done wins and err is not asserted; done and err are never high together.
REQ-021 RELEASE: grant is held, and the FSM waits until lcd_sendingDone is low, then clears grant and goes to IDLE; minimum one cycle in RELEASE.
REQ-022 req is ignored outside IDLE; req deasserted mid-transfer does not abort the transfer.
REQ-023 line inputs are ignored after the latch; lcd_line1/lcd_line2 are stable for the whole transfer and keep their value in IDLE.
REQ-024 Back-to-back: with pending req in IDLE, the next grant is registered on the first IDLE cycle (no bubble beyond RELEASE exit).
REQ-025 Timeout counter is 24 bits and never wraps; it saturates at TIMEOUT_CYCLES-1.

Reset
REQ-026 RESET high -> state IDLE, grant=0, done=0, err=0, lcd_sendText=0, lcd_line1=0, lcd_line2=0, ptr=0, counter=0, immediately and without waiting for CLK.
REQ-027 RESET during SEND or RELEASE aborts the transfer with no done or err pulse; after release, requester 0 has highest priority.

Verification
REQ-028 req=3'b001, done returns 5 cycles after lcd_sendText rises -> grant=001, lcd_line1=line1_0, done=001 for 1 cycle, grant=000 after lcd_sendingDone falls.
REQ-029 req=3'b111 held across three transfers -> grant order 001, 010, 100, then 001 again; never two grant bits set.
REQ-030 TIMEOUT_CYCLES=8, lcd_sendingDone held 0 -> lcd_sendText high exactly 8 cycles, err=owner for 1 cycle, done never asserted, ptr advances.
REQ-031 lcd_sendingDone held high for 10 cycles after the transfer -> RELEASE holds grant until it falls; a pending req is granted the following cycle.
REQ-032 RESET asserted mid-SEND with req=010 -> all outputs 0 asynchronously; after release with req=011, requester 0 is granted first.
REQ-033 line1_0 changed during SEND -> lcd_line1 keeps the value latched at the grant edge.
